hazard_scoreboard: RTL and testbench

//  Parametrised successor to the combinational load-use hazard unit. It keeps a

---
 rtl/hazard_scoreboard_if.sv | 30 +++
 rtl/hazard_scoreboard.sv | 153 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus between the decode/pipeline control (master) and hazard_scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int unsigned NSTAGE = 4
);
  logic              id_valid;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [4:0]        id_rd;
  logic              id_wr;
  logic [1:0]        id_cls;
  logic [NSTAGE-1:0] flush_req;
  logic              pc_pause;
  logic [NSTAGE-1:0] pipe_pause;
  logic [NSTAGE-1:0] pipe_bubble;
  logic              sb_full;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_wr, id_cls, flush_req,
    input  pc_pause, pipe_pause, pipe_bubble, sb_full
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_wr, id_cls, flush_req,
    output pc_pause, pipe_pause, pipe_bubble, sb_full
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight multi-cycle register writes driving ID stall/flush controls.
// Optional WAW ordering check enabled by defining HAZARD_WAW_CHECK_EN.
module hazard_scoreboard #(
  parameter int unsigned NSTAGE   = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MD_LAT   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
);
  localparam int unsigned CW = $clog2(MD_LAT + 1);
  localparam int unsigned AW = $clog2(NSTAGE);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] AGE_MAX = AW'(NSTAGE - 1);

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_MULDIV = 2'd2,
    CLS_RSVD   = 2'd3
  } cls_e;

  logic [DEPTH-1:0] r_valid;
  logic [4:0]       r_rd  [DEPTH];
  logic [CW-1:0]    r_cnt [DEPTH];
  logic [AW-1:0]    r_age [DEPTH];

  logic [CW-1:0]     w_lat;
  logic              w_hit1, w_hit2;
  logic              w_raw_stall, w_full_stall, w_stall, w_waw;
  logic              w_sb_full;
  logic              w_flush_any;
  logic [AW-1:0]     w_k;
  logic [NSTAGE-1:0] w_flush_mask;
  logic              w_issue_fire, w_alloc, w_alloc_ok;
  logic [IW-1:0]     w_alloc_idx;

  always_comb begin
    unique case (cls_e'(bus.id_cls))
      CLS_LOAD:   w_lat = CW'(LOAD_LAT);
      CLS_MULDIV: w_lat = CW'(MD_LAT);
      default:    w_lat = '0;
    endcase
  end

  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && r_cnt[i] != '0) begin
        if (r_rd[i] == bus.id_rs1) w_hit1 = 1'b1;
        if (r_rd[i] == bus.id_rs2) w_hit2 = 1'b1;
      end
    end
  end

`ifdef HAZARD_WAW_CHECK_EN
  logic w_waw_hit;
  // An older op still outstanding longer than the new one would land its result last.
  always_comb begin
    w_waw_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && r_rd[i] == bus.id_rd && r_cnt[i] > w_lat) w_waw_hit = 1'b1;
    end
  end
  assign w_waw = bus.id_wr && (bus.id_rd != '0) && w_waw_hit;
`else
  assign w_waw = 1'b0;
`endif

  assign w_sb_full    = &r_valid;
  assign w_raw_stall  = bus.id_valid &&
                        ((bus.id_rs1_used && bus.id_rs1 != '0 && w_hit1) ||
                         (bus.id_rs2_used && bus.id_rs2 != '0 && w_hit2));
  assign w_full_stall = bus.id_valid &&
                        ((bus.id_wr && w_lat != '0 && w_sb_full) || w_waw);
  assign w_stall      = w_raw_stall || w_full_stall;

  // Stage s lives at bit NSTAGE-1-s; the last set stage found is the deepest.
  always_comb begin
    w_flush_any  = |bus.flush_req;
    w_k          = '0;
    w_flush_mask = '0;
    for (int unsigned s = 0; s < NSTAGE; s++) begin
      if (bus.flush_req[NSTAGE-1-s]) w_k = AW'(s);
    end
    for (int unsigned s = 0; s < NSTAGE; s++) begin
      if (w_flush_any && AW'(s) <= w_k) w_flush_mask[NSTAGE-1-s] = 1'b1;
    end
  end

  always_comb begin
    bus.pc_pause    = 1'b0;
    bus.pipe_pause  = '0;
    bus.pipe_bubble = '0;
    if (w_flush_any) begin
      bus.pc_pause    = 1'b1;
      bus.pipe_bubble = w_flush_mask;
    end else if (w_stall) begin
      bus.pc_pause               = 1'b1;
      bus.pipe_pause[NSTAGE-1]   = 1'b1;
      bus.pipe_bubble[NSTAGE-2]  = 1'b1;
    end
  end

  assign bus.sb_full = w_sb_full;

  // A slot whose count has run out is freed at this edge and may be reused at once.
  always_comb begin
    w_alloc_ok  = 1'b0;
    w_alloc_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!w_alloc_ok && (!r_valid[i] || r_cnt[i] == '0)) begin
        w_alloc_ok  = 1'b1;
        w_alloc_idx = IW'(i);
      end
    end
  end

  assign w_issue_fire = bus.id_valid && !w_stall && !w_flush_any;
  assign w_alloc      = w_issue_fire && bus.id_wr && (bus.id_rd != '0) &&
                        (w_lat != '0) && w_alloc_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rd[i]  <= '0;
        r_cnt[i] <= '0;
        r_age[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_alloc && w_alloc_idx == IW'(i)) begin
          r_valid[i] <= 1'b1;
          r_rd[i]    <= bus.id_rd;
          r_cnt[i]   <= w_lat;
          r_age[i]   <= '0;
        end else if (r_valid[i]) begin
          // age+1 <= k means the producer sits in a flushed stage.
          if (r_cnt[i] == '0 || (w_flush_any && r_age[i] < w_k)) begin
            r_valid[i] <= 1'b0;
          end else begin
            r_cnt[i] <= r_cnt[i] - CW'(1);
            r_age[i] <= (r_age[i] == AGE_MAX) ? r_age[i] : r_age[i] + AW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (NSTAGE=4, DEPTH=4, LOAD_LAT=1, MD_LAT=8).
module tb_hazard_scoreboard;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hazard_scoreboard_if #(.NSTAGE(4)) bus ();

  hazard_scoreboard #(
    .NSTAGE(4),
    .DEPTH(4),
    .LOAD_LAT(1),
    .MD_LAT(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {pc_pause, pipe_pause[3:0], pipe_bubble[3:0], sb_full}
  logic [9:0] obs;
  assign obs = {bus.pc_pause, bus.pipe_pause, bus.pipe_bubble, bus.sb_full};

  localparam logic [9:0] IDLE  = 10'b0_0000_0000_0;
  localparam logic [9:0] STALL = 10'b1_1000_0100_0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [1:0] cls, input logic [4:0] rd,
                        input logic wr, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    bus.id_valid    = v;
    bus.id_cls      = cls;
    bus.id_rd       = rd;
    bus.id_wr       = wr;
    bus.id_rs1      = rs1;
    bus.id_rs1_used = u1;
    bus.id_rs2      = rs2;
    bus.id_rs2_used = u2;
    bus.flush_req   = 4'b0000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    set_id(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_id(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL reset_initial obs=%b exp=%b", obs, IDLE); end
    step();
    rst_n = 1'b1;
    step();
    set_id(1'b1, 2'd1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_id(1'b1, 2'd2, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_id(1'b1, 2'd0, 5'd6, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
    #1;
    total++;
    if (obs !== STALL) begin bad++; $display("FAIL reset_prestall obs=%b exp=%b", obs, STALL); end
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL reset_async obs=%b exp=%b", obs, IDLE); end
    step();
    rst_n = 1'b1;
    #1;
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL reset_nostall obs=%b exp=%b", obs, IDLE); end
  endtask

  task automatic test_load_use();
    apply_reset();
    set_id(1'b1, 2'd1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL load_issue obs=%b exp=%b", obs, IDLE); end
    step();
    set_id(1'b1, 2'd0, 5'd6, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1);
    #1;
    total++;
    if (obs !== STALL) begin bad++; $display("FAIL loaduse_stall obs=%b exp=%b", obs, STALL); end
    step();
    #1;
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL loaduse_release obs=%b exp=%b", obs, IDLE); end
    step();
  endtask

  task automatic test_muldiv();
    logic [9:0] exp;
    apply_reset();
    set_id(1'b1, 2'd2, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_id(1'b1, 2'd0, 5'd8, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL md_x0_consumer obs=%b exp=%b", obs, IDLE); end
    set_id(1'b1, 2'd0, 5'd8, 1'b1, 5'd7, 1'b0, 5'd7, 1'b0);
    #1;
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL md_unused_src obs=%b exp=%b", obs, IDLE); end
    set_id(1'b1, 2'd0, 5'd8, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1);
    for (int i = 0; i < 9; i++) begin
      #1;
      exp = (i < 8) ? STALL : IDLE;
      total++;
      if (obs !== exp) begin bad++; $display("FAIL md_stall_cycle%0d obs=%b exp=%b", i, obs, exp); end
      step();
    end
  endtask

  task automatic test_flush_kill();
    apply_reset();
    set_id(1'b1, 2'd2, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_id(1'b1, 2'd0, 5'd6, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
    bus.flush_req = 4'b0100;
    #1;
    total++;
    if (obs !== 10'b1_0000_1100_0) begin bad++; $display("FAIL flush_ex obs=%b exp=%b", obs, 10'b1_0000_1100_0); end
    step();
    set_id(1'b1, 2'd0, 5'd6, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
    #1;
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL flush_killed obs=%b exp=%b", obs, IDLE); end
    step();
    set_id(1'b1, 2'd2, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_id(1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    bus.flush_req = 4'b1010;
    #1;
    total++;
    if (obs !== 10'b1_0000_1110_0) begin bad++; $display("FAIL flush_deepest obs=%b exp=%b", obs, 10'b1_0000_1110_0); end
    bus.flush_req = 4'b1000;
    #1;
    total++;
    if (obs !== 10'b1_0000_1000_0) begin bad++; $display("FAIL flush_id obs=%b exp=%b", obs, 10'b1_0000_1000_0); end
    step();
    set_id(1'b1, 2'd0, 5'd6, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0);
    #1;
    total++;
    if (obs !== STALL) begin bad++; $display("FAIL flush_survivor obs=%b exp=%b", obs, STALL); end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 2'd2, 5'(10 + i), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      total++;
      if (obs !== IDLE) begin bad++; $display("FAIL full_fill%0d obs=%b exp=%b", i, obs, IDLE); end
      step();
    end
    set_id(1'b1, 2'd0, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    total++;
    if (obs !== 10'b0_0000_0000_1) begin bad++; $display("FAIL full_alu_ok obs=%b exp=%b", obs, 10'b0_0000_0000_1); end
    set_id(1'b1, 2'd2, 5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    total++;
    if (obs !== 10'b1_1000_0100_1) begin bad++; $display("FAIL full_stall obs=%b exp=%b", obs, 10'b1_1000_0100_1); end
    bus.flush_req = 4'b0100;
    #1;
    total++;
    if (obs !== 10'b1_0000_1100_1) begin bad++; $display("FAIL full_flush_wins obs=%b exp=%b", obs, 10'b1_0000_1100_1); end
    step();
    set_id(1'b1, 2'd2, 5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL full_after_kill obs=%b exp=%b", obs, IDLE); end
    step();
  endtask

  task automatic test_waw();
    apply_reset();
    set_id(1'b1, 2'd2, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    set_id(1'b1, 2'd1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
`ifdef HAZARD_WAW_CHECK_EN
    for (int i = 0; i < 8; i++) begin
      logic [9:0] exp;
      #1;
      exp = (i < 7) ? STALL : IDLE;
      total++;
      if (obs !== exp) begin bad++; $display("FAIL waw_cycle%0d obs=%b exp=%b", i, obs, exp); end
      step();
    end
`else
    #1;
    total++;
    if (obs !== IDLE) begin bad++; $display("FAIL waw_off obs=%b exp=%b", obs, IDLE); end
    step();
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_use();
    test_muldiv();
    test_flush_kill();
    test_full();
    test_waw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
